// File: rtl/ochiba_hazard_ctrl.sv
// ochiba_hazard_ctrl
// Pipeline sequencing controller for the six-stage RV32I core
// (IF, ID, RF, Ex, MA, WB). Resolves the WB redirect, the MA data-memory
// wait, the Ex multi-cycle busy flag and the load-use hazard into the
// per-stage clear/stall controls. Also holds the post-redirect fetch-flush
// window, an Ex-busy watchdog and stall/flush event counters.
module ochiba_hazard_ctrl #(
    parameter int unsigned FLUSH_HOLD = 2,
    parameter int unsigned EX_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch,
    input  logic             Exnow,
    input  logic             ma_mem_req,
    input  logic             dmem_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       rf_rd,
    input  logic             rf_load,
    output logic             IFREGclear,
    output logic             IDREGclear,
    output logic             RFREGclear,
    output logic             ExREGclear,
    output logic             MAREGclear,
    output logic             WBREGclear,
    output logic             IFREGstall,
    output logic             IDREGstall,
    output logic             RFREGstall,
    output logic             ExREGstall,
    output logic             MAREGstall,
    output logic             ex_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]  HOLD_INIT   = 4'(FLUSH_HOLD);
    localparam logic [16:0] TIMEOUT_LIM = 17'(EX_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [3:0]       hold;
    logic [3:0]       hold_next;
    logic [15:0]      wd;
    logic [15:0]      wd_next;
    logic             timeout_next;
    logic [CNT_W-1:0] stall_next;
    logic [CNT_W-1:0] flush_next;

    logic             mem_wait;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;
    logic             any_stall;

    // Hazard source decode; x0 is never a real destination so it cannot hazard
    assign mem_wait = ma_mem_req & ~dmem_ready;
    assign rs1_hit  = id_use1 & (id_rs1 == rf_rd);
    assign rs2_hit  = id_use2 & (id_rs2 == rf_rd);
    assign load_use = rf_load & (rf_rd != 5'd0) & (rs1_hit | rs2_hit);

    // State register: flush window FSM, watchdog, sticky timeout and counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RUN;
            hold       <= 4'd0;
            wd         <= 16'd0;
            ex_timeout <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_next;
            hold       <= hold_next;
            wd         <= wd_next;
            ex_timeout <= timeout_next;
            stall_cnt  <= stall_next;
            flush_cnt  <= flush_next;
        end
    end

    // Next-state logic: a redirect (re)opens the fetch-flush window, which
    // otherwise counts down regardless of any stall and closes at 1
    always_comb begin
        state_next = state;
        hold_next  = hold;
        if (branch) begin
            if (HOLD_INIT != 4'd0) begin
                state_next = FLUSH;
                hold_next  = HOLD_INIT;
            end else begin
                state_next = RUN;
                hold_next  = 4'd0;
            end
        end else if (state == FLUSH) begin
            if (hold <= 4'd1) begin
                state_next = RUN;
                hold_next  = 4'd0;
            end else begin
                hold_next = hold - 4'd1;
            end
        end
    end

    // Watchdog: counts consecutive busy cycles, saturates, and latches the
    // timeout flag on the edge where the count reaches the limit
    always_comb begin
        wd_next      = 16'd0;
        timeout_next = ex_timeout;
        if (Exnow) begin
            if (wd == 16'hFFFF) begin
                wd_next = wd;
            end else begin
                wd_next = wd + 16'd1;
            end
            if (({1'b0, wd} + 17'd1) >= TIMEOUT_LIM) begin
                timeout_next = 1'b1;
            end
        end
    end

    // Event counters: stalled cycles and accepted redirects, both wrapping
    always_comb begin
        stall_next = stall_cnt + CNT_W'(any_stall);
        flush_next = flush_cnt + CNT_W'(branch);
    end

    // Output logic: reset forces a full flush, otherwise the highest-priority
    // source alone drives the controls, with the flush window ORed into IF
    always_comb begin
        IFREGclear = 1'b0;
        IDREGclear = 1'b0;
        RFREGclear = 1'b0;
        ExREGclear = 1'b0;
        MAREGclear = 1'b0;
        WBREGclear = 1'b0;
        IFREGstall = 1'b0;
        IDREGstall = 1'b0;
        RFREGstall = 1'b0;
        ExREGstall = 1'b0;
        MAREGstall = 1'b0;
        if (!reset) begin
            IFREGclear = 1'b1;
            IDREGclear = 1'b1;
            RFREGclear = 1'b1;
            ExREGclear = 1'b1;
            MAREGclear = 1'b1;
            WBREGclear = 1'b1;
        end else begin
            if (branch) begin
                IFREGclear = 1'b1;
                IDREGclear = 1'b1;
                RFREGclear = 1'b1;
                ExREGclear = 1'b1;
                MAREGclear = 1'b1;
            end else if (mem_wait) begin
                IFREGstall = 1'b1;
                IDREGstall = 1'b1;
                RFREGstall = 1'b1;
                ExREGstall = 1'b1;
                MAREGstall = 1'b1;
                WBREGclear = 1'b1;
            end else if (Exnow) begin
                IFREGstall = 1'b1;
                IDREGstall = 1'b1;
                RFREGstall = 1'b1;
                ExREGstall = 1'b1;
                MAREGclear = 1'b1;
            end else if (load_use) begin
                IFREGstall = 1'b1;
                IDREGstall = 1'b1;
                RFREGclear = 1'b1;
            end
            if (state == FLUSH) begin
                IFREGclear = 1'b1;
            end
        end
    end

    // Any stage held this cycle counts as a stalled cycle
    assign any_stall = IFREGstall | IDREGstall | RFREGstall | ExREGstall | MAREGstall;

endmodule

// File: tb/tb_ochiba_hazard_ctrl.sv
// tb_ochiba_hazard_ctrl
// Self-checking bench: a constant vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_ochiba_hazard_ctrl;

    localparam int FLUSH_HOLD = 2;
    localparam int EX_TIMEOUT = 64;
    localparam int CNT_W      = 32;

    logic             clk;
    logic             reset;
    logic             branch;
    logic             Exnow;
    logic             ma_mem_req;
    logic             dmem_ready;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [4:0]       rf_rd;
    logic             rf_load;
    logic             IFREGclear;
    logic             IDREGclear;
    logic             RFREGclear;
    logic             ExREGclear;
    logic             MAREGclear;
    logic             WBREGclear;
    logic             IFREGstall;
    logic             IDREGstall;
    logic             RFREGstall;
    logic             ExREGstall;
    logic             MAREGstall;
    logic             ex_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    ochiba_hazard_ctrl #(
        .FLUSH_HOLD (FLUSH_HOLD),
        .EX_TIMEOUT (EX_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .branch     (branch),
        .Exnow      (Exnow),
        .ma_mem_req (ma_mem_req),
        .dmem_ready (dmem_ready),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use1    (id_use1),
        .id_use2    (id_use2),
        .rf_rd      (rf_rd),
        .rf_load    (rf_load),
        .IFREGclear (IFREGclear),
        .IDREGclear (IDREGclear),
        .RFREGclear (RFREGclear),
        .ExREGclear (ExREGclear),
        .MAREGclear (MAREGclear),
        .WBREGclear (WBREGclear),
        .IFREGstall (IFREGstall),
        .IDREGstall (IDREGstall),
        .RFREGstall (RFREGstall),
        .ExREGstall (ExREGstall),
        .MAREGstall (MAREGstall),
        .ex_timeout (ex_timeout),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       branch;
        logic       exnow;
        logic       mreq;
        logic       dready;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       load;
        logic [5:0] clears;
        logic [4:0] stalls;
    } vec_t;

    vec_t vecs[14];

    int checks = 0;
    int passes = 0;

    // Reference model state: remaining flush-window cycles, busy run length
    int          m_flush_left = 0;
    int          m_busy_run   = 0;
    bit          m_timeout    = 1'b0;
    int unsigned m_stalls     = 0;
    int unsigned m_flushes    = 0;

    function automatic logic [5:0] act_clears();
        return {IFREGclear, IDREGclear, RFREGclear, ExREGclear, MAREGclear, WBREGclear};
    endfunction

    function automatic logic [4:0] act_stalls();
        return {IFREGstall, IDREGstall, RFREGstall, ExREGstall, MAREGstall};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Expected controls from the priority rules applied to the current inputs
    task automatic model_outputs(output logic [5:0] c, output logic [4:0] s);
        bit hit;
        c = 6'b000000;
        s = 5'b00000;
        hit = rf_load && (rf_rd != 0) &&
              ((id_use1 && id_rs1 == rf_rd) || (id_use2 && id_rs2 == rf_rd));
        if (!reset) begin
            c = 6'b111111;
        end else begin
            if (branch)                        c = 6'b111110;
            else if (ma_mem_req && !dmem_ready) begin c = 6'b000001; s = 5'b11111; end
            else if (Exnow)                    begin c = 6'b000010; s = 5'b11110; end
            else if (hit)                      begin c = 6'b001000; s = 5'b11000; end
            if (m_flush_left > 0) c[5] = 1'b1;
        end
    endtask

    // Advance the model by one clock edge using the inputs held this cycle
    task automatic model_step();
        logic [5:0] c;
        logic [4:0] s;
        model_outputs(c, s);
        if (!reset) begin
            m_flush_left = 0;
            m_busy_run   = 0;
            m_timeout    = 1'b0;
            m_stalls     = 0;
            m_flushes    = 0;
        end else begin
            if (s != 0) m_stalls++;
            if (branch) begin
                m_flushes++;
                m_flush_left = FLUSH_HOLD;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
            if (Exnow) begin
                if (m_busy_run < 65535) m_busy_run++;
                if (m_busy_run >= EX_TIMEOUT) m_timeout = 1'b1;
            end else begin
                m_busy_run = 0;
            end
        end
    endtask

    // Wait to mid-cycle and compare every output with the model
    task automatic settle();
        logic [5:0] c;
        logic [4:0] s;
        #4;
        model_outputs(c, s);
        check("model_clears", 32'(act_clears()), 32'(c));
        check("model_stalls", 32'(act_stalls()), 32'(s));
        check("model_ex_timeout", 32'(ex_timeout), 32'(m_timeout));
        check("model_stall_cnt", stall_cnt, m_stalls);
        check("model_flush_cnt", flush_cnt, m_flushes);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v, input logic rst);
        reset      = rst;
        branch     = v.branch;
        Exnow      = v.exnow;
        ma_mem_req = v.mreq;
        dmem_ready = v.dready;
        id_rs1     = v.rs1;
        id_rs2     = v.rs2;
        id_use1    = v.use1;
        id_use2    = v.use2;
        rf_rd      = v.rd;
        rf_load    = v.load;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = vecs[0];
        apply_stimulus(z, 1'b1);
    endtask

    task automatic reset_cycle();
        idle_inputs();
        reset = 1'b0;
        settle();
        advance();
        reset = 1'b1;
    endtask

    task automatic check_output(input string name, input logic [5:0] c, input logic [4:0] s);
        check({name, "_clears"}, 32'(act_clears()), 32'(c));
        check({name, "_stalls"}, 32'(act_stalls()), 32'(s));
    endtask

    initial begin
        //            br ex mr dr rs1   rs2   u1 u2 rd    ld  clears      stalls
        vecs[0]  = '{0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b000000, 5'b00000};
        vecs[1]  = '{1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b111110, 5'b00000};
        vecs[2]  = '{0, 0, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b000001, 5'b11111};
        vecs[3]  = '{0, 0, 1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b000000, 5'b00000};
        vecs[4]  = '{0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b000010, 5'b11110};
        vecs[5]  = '{0, 0, 0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 6'b001000, 5'b11000};
        vecs[6]  = '{0, 0, 0, 0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 6'b001000, 5'b11000};
        vecs[7]  = '{0, 0, 0, 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 6'b000000, 5'b00000};
        vecs[8]  = '{0, 0, 0, 0, 5'd7, 5'd0, 0, 0, 5'd7, 1, 6'b000000, 5'b00000};
        vecs[9]  = '{0, 0, 0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 0, 6'b000000, 5'b00000};
        vecs[10] = '{0, 1, 0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 6'b000010, 5'b11110};
        vecs[11] = '{1, 1, 1, 0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 6'b111110, 5'b00000};
        vecs[12] = '{0, 1, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 6'b000001, 5'b11111};
        vecs[13] = '{0, 0, 0, 0, 5'd3, 5'd4, 1, 1, 5'd4, 1, 6'b001000, 5'b11000};

        idle_inputs();
        reset = 1'b0;
        advance();

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            reset = 1'b0;
            settle();
            check_output("reset_hold", 6'b111111, 5'b00000);
            advance();
        end
        idle_inputs();
        settle();
        check_output("after_reset", 6'b000000, 5'b00000);
        check("after_reset_stall_cnt", stall_cnt, 32'd0);
        check("after_reset_flush_cnt", flush_cnt, 32'd0);
        advance();

        // Single-cycle combinational vectors, each from a fresh reset
        for (int i = 0; i < 14; i++) begin
            reset_cycle();
            apply_stimulus(vecs[i], 1'b1);
            settle();
            check_output($sformatf("vec%0d", i), vecs[i].clears, vecs[i].stalls);
            advance();
        end

        // Branch pulse followed by the fetch-flush window
        reset_cycle();
        branch = 1'b1;
        settle();
        check_output("branch_pulse", 6'b111110, 5'b00000);
        advance();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            settle();
            check_output("flush_window", 6'b100000, 5'b00000);
            advance();
        end
        settle();
        check_output("flush_done", 6'b000000, 5'b00000);
        check("flush_cnt_one", flush_cnt, 32'd1);
        advance();

        // Memory wait concurrent with Ex busy for four cycles
        reset_cycle();
        for (int i = 0; i < 4; i++) begin
            ma_mem_req = 1'b1;
            dmem_ready = 1'b0;
            Exnow      = 1'b1;
            settle();
            check_output("memwait_exbusy", 6'b000001, 5'b11111);
            advance();
        end
        idle_inputs();
        settle();
        check("memwait_stall_cnt", stall_cnt, 32'd4);
        advance();

        // Watchdog: 64 busy cycles, flag stays until reset
        reset_cycle();
        for (int i = 0; i < EX_TIMEOUT; i++) begin
            Exnow = 1'b1;
            settle();
            check("timeout_early", 32'(ex_timeout), 32'd0);
            advance();
        end
        idle_inputs();
        settle();
        check("timeout_set", 32'(ex_timeout), 32'd1);
        advance();
        settle();
        check("timeout_sticky", 32'(ex_timeout), 32'd1);
        advance();
        reset_cycle();
        settle();
        check("timeout_cleared", 32'(ex_timeout), 32'd0);
        advance();

        // Branch beats mem-wait, then a second branch reloads the window
        reset_cycle();
        branch     = 1'b1;
        ma_mem_req = 1'b1;
        dmem_ready = 1'b0;
        settle();
        check_output("branch_over_memwait", 6'b111110, 5'b00000);
        advance();
        idle_inputs();
        branch = 1'b1;
        settle();
        check_output("branch_in_flush", 6'b111110, 5'b00000);
        advance();
        idle_inputs();
        settle();
        check("flush_cnt_two", flush_cnt, 32'd2);
        check_output("reload_window1", 6'b100000, 5'b00000);
        advance();
        settle();
        check_output("reload_window2", 6'b100000, 5'b00000);
        advance();
        settle();
        check_output("reload_done", 6'b000000, 5'b00000);
        advance();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 99) != 0);
            branch     = ($urandom_range(0, 9) == 0);
            Exnow      = ($urandom_range(0, 3) == 0);
            ma_mem_req = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 1) == 0);
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            id_use1    = ($urandom_range(0, 1) == 0);
            id_use2    = ($urandom_range(0, 1) == 0);
            rf_rd      = 5'($urandom_range(0, 3));
            rf_load    = ($urandom_range(0, 1) == 0);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ochiba_hazard_ctrl.md
Name: ochiba_hazard_ctrl

Overview:
- Pipeline sequencing controller for the six-stage RV32I core (IF, ID, RF, Ex, MA, WB).
- Drives every per-stage clear and stall input of the datapath from four sources:
  - the WB-stage branch redirect,
  - the Ex multi-cycle busy flag,
  - the MA data-memory wait handshake,
  - load-use hazard compares.
- Also holds the post-redirect fetch-flush window, an Ex-busy watchdog and stall/flush event counters.

Parameters:
FLUSH_HOLD, 2, extra cycles IFREGclear stays high after a redirect (covers instruction-memory latency); legal range 0..15
EX_TIMEOUT, 64, consecutive Exnow cycles after which ex_timeout sets; legal range 1..65535
CNT_W, 32, width of the event counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block
branch  input  1  WB redirect (datapath pcwrcntl)
Exnow  input  1  Ex stage busy with a multi-cycle operation
ma_mem_req  input  1  MA-stage instruction is accessing data memory
dmem_ready  input  1  data memory completes the access this cycle
id_rs1  input  5  rs1 of the instruction in the ID-output register
id_rs2  input  5  rs2 of the instruction in the ID-output register
id_use1  input  1  ID instruction reads rs1
id_use2  input  1  ID instruction reads rs2
rf_rd  input  5  rd of the instruction in the RF-output register
rf_load  input  1  RF-output instruction is a load
IFREGclear, IDREGclear, RFREGclear, ExREGclear, MAREGclear, WBREGclear  output  1 each  stage register clear
IFREGstall, IDREGstall, RFREGstall, ExREGstall, MAREGstall  output  1 each  stage register hold
ex_timeout  output  1  sticky watchdog flag
stall_cnt  output  CNT_W  cycles with any stall asserted
flush_cnt  output  CNT_W  number of accepted redirects

Behaviour:
- Stall and clear outputs are combinational from the inputs and registered state; same-cycle response, no added latency.
- Counters, FSM state and ex_timeout are registered.

Reset (reset==0 at a clk edge):
- FSM goes to RUN; flush counter, watchdog counter, stall_cnt, flush_cnt and ex_timeout all go to 0.
- While reset==0 the outputs are forced: all six clears = 1, all five stalls = 0.
- Reset asserted mid-flush or mid-stall abandons that operation immediately.

Hazard priority, highest first; only the winning source drives outputs that cycle:
1. branch=1: clear IF, ID, RF, Ex and MA; WBREGclear=0 (the branching instruction commits); all stalls = 0. Overrides mem-wait, Ex-busy and load-use. flush_cnt += 1. FSM goes to FLUSH with the counter loaded to FLUSH_HOLD. If FLUSH_HOLD=0, the FSM stays in RUN.
2. Mem wait (ma_mem_req=1 and dmem_ready=0): stall IF, ID, RF, Ex and MA; WBREGclear=1 (bubble into WB).
3. Exnow=1: stall IF, ID, RF and Ex; MAREGclear=1 (bubble into MA).
4. Load-use: rf_load=1 and rf_rd!=0 and ((id_use1 and id_rs1==rf_rd) or (id_use2 and id_rs2==rf_rd)). Stall IF and ID; RFREGclear=1. Holds for one cycle per occurrence (the load then advances).
- With no source active, all stalls and clears are 0.

FSM:
- RUN: normal operation.
- FLUSH: IFREGclear=1 every cycle, ORed with the other sources. The counter decrements each cycle and the FSM returns to RUN on the cycle the counter reaches 1.
  - branch while in FLUSH: the counter reloads to FLUSH_HOLD and flush_cnt increments again.
  - A stall in FLUSH does not pause the counter.

Watchdog:
- 16-bit counter; increments while Exnow=1, clears when Exnow=0.
- ex_timeout sets when the counter reaches EX_TIMEOUT. Cleared only by reset.
- The counter saturates at 0xFFFF; it never wraps.

Counters:
- stall_cnt increments on any cycle where any *REGstall is 1.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- Reset held low 3 cycles, then released: during reset all clears=1 and stalls=0; after release all outputs=0, stall_cnt=0, flush_cnt=0.
- branch pulse 1 cycle, FLUSH_HOLD=2: that cycle IF/ID/RF/Ex/MA clears=1 and WBREGclear=0; next 2 cycles IFREGclear=1 only; third cycle all 0; flush_cnt=1.
- ma_mem_req=1, dmem_ready=0 for 4 cycles, Exnow=1 concurrently: stalls IF..MA=1 and WBREGclear=1 for 4 cycles, MAREGclear=0; stall_cnt=4.
- rf_load=1, rf_rd=5, id_rs2=5, id_use2=1: IF/ID stall=1 and RFREGclear=1 for one cycle. Repeat with rf_rd=0: no stall.
- Exnow held 64 cycles with EX_TIMEOUT=64: ex_timeout rises on cycle 64 and stays 1 after Exnow drops; cleared only by reset.
- branch and mem-wait in the same cycle: branch outputs win, MAREGstall=0, WBREGclear=0; branch again 1 cycle into FLUSH: counter reloads and flush_cnt=2.
